// File: rtl/decoder_rr_scheduler.sv
// Round-robin grant scheduler driving a 4-to-16 decoder select/enable pair.
// One grant at a time, bounded by HOLD_MAX cycles.
// Every release is followed by a one-cycle GAP so that decoder outputs break before make.
module decoder_rr_scheduler #(
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic        en416,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic       en_q;
  logic       to_q, to_d;
  logic [3:0] winner;
  logic [3:0] idx;
  logic       found;
  logic       hold_hit;
  logic       owner_req;

  // Pick the first set request at or above ptr, wrapping modulo 16.
  // The loop scans downward, so the smallest offset from ptr is assigned last and wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = ptr_q + 4'(i);
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, watch the release conditions in GRANT.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    to_d      = 1'b0;
    owner_req = req[sel_q];
    hold_hit  = (hold_q == HoldLast);
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          sel_d   = winner;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (done || !owner_req || hold_hit) begin
          state_d = StGap;
          ptr_d   = sel_q + 4'd1;
          // A done pulse or a dropped request takes priority, so the release counts as normal.
          to_d    = hold_hit && !done && owner_req;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset is asynchronous, so en416 drops without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      en_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      en_q    <= (state_d == StGrant);
      to_q    <= to_d;
    end
  end

  assign sel     = sel_q;
  assign en416   = en_q;
  assign busy    = (state_q != StIdle);
  assign timeout = to_q;

endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// Bench for decoder_rr_scheduler.
// Two instances (HOLD_MAX = 255 and HOLD_MAX = 4) share one stimulus, and each has its own
// grant-level reference model. Directed vectors with literal expectations pin the models.
module tb_decoder_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [3:0]  a_sel, b_sel;
  logic        a_en, b_en, a_busy, b_busy, a_to, b_to;
  logic        run;
  int          n_vec;
  int          n_err;
  int          z;
  int          n;

  decoder_rr_scheduler dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (a_sel),
    .en416   (a_en),
    .busy    (a_busy),
    .timeout (a_to)
  );

  decoder_rr_scheduler #(.HOLD_MAX(4)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (b_sel),
    .en416   (b_en),
    .busy    (b_busy),
    .timeout (b_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: is a grant held, who owns it, how long it has lasted, and whether the
  // break cycle after a release is still pending.
  typedef struct packed {
    logic       en;
    logic [3:0] sel;
    logic       gap;
    logic       to;
    logic [3:0] ptr;
    logic [8:0] len;
  } model_t;

  model_t ma, mb;

  function automatic model_t step(model_t m, logic [15:0] r, logic d, int hold);
    model_t n_m;
    bit     found;
    n_m    = m;
    n_m.to = 1'b0;
    found  = 1'b0;
    if (m.en) begin
      n_m.len = m.len + 9'd1;
      if (d || !r[m.sel] || int'(n_m.len) == hold) begin
        n_m.en  = 1'b0;
        n_m.gap = 1'b1;
        n_m.ptr = 4'((int'(m.sel) + 1) % 16);
        n_m.to  = (int'(n_m.len) == hold) && !d && r[m.sel];
      end
    end else if (m.gap) begin
      n_m.gap = 1'b0;
    end else if (r != 16'h0) begin
      for (int k = 0; k < 16; k++) begin
        int j;
        j = (int'(m.ptr) + k) % 16;
        if (!found && r[j]) begin
          found   = 1'b1;
          n_m.sel = 4'(j);
        end
      end
      n_m.en  = 1'b1;
      n_m.len = '0;
    end
    return n_m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= step(ma, req, done, 255);
      mb <= step(mb, req, done, 4);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against their models on every falling edge.
  always @(negedge clk) begin
    if (run) begin
      chk("a.sel", int'(a_sel), int'(ma.sel));
      chk("a.en416", int'(a_en), int'(ma.en));
      chk("a.busy", int'(a_busy), int'(ma.en | ma.gap));
      chk("a.timeout", int'(a_to), int'(ma.to));
      chk("b.sel", int'(b_sel), int'(mb.sel));
      chk("b.en416", int'(b_en), int'(mb.en));
      chk("b.busy", int'(b_busy), int'(mb.en | mb.gap));
      chk("b.timeout", int'(b_to), int'(mb.to));
    end
  end

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait for dut_b's enable, counting the low cycles seen first; bounded.
  task automatic wait_en(input int bound, output int zeros);
    zeros = 0;
    while (!b_en && zeros < bound) begin
      zeros++;
      @(negedge clk);
    end
    chk("grant_seen", int'(b_en), 1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    run   = 1'b0;
    req   = '0;
    done  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    chk("rst.en416", int'(b_en), 0);
    chk("rst.sel", int'(b_sel), 0);
    chk("rst.busy", int'(b_busy), 0);
    chk("rst.timeout", int'(b_to), 0);

    // Single requester, one cycle of latency, released by done.
    req = 16'h0001;
    @(negedge clk);
    chk("r029.en416", int'(b_en), 1);
    chk("r029.sel", int'(b_sel), 0);
    done = 1'b1;
    req  = 16'h0000;
    @(negedge clk);
    done = 1'b0;
    chk("r029.rel_en416", int'(b_en), 0);
    chk("r029.timeout", int'(b_to), 0);
    // done outside GRANT is ignored.
    done = 1'b1;
    repeat (3) @(negedge clk);
    done = 1'b0;
    chk("idle_done.en416", int'(b_en), 0);
    chk("idle_done.busy", int'(b_busy), 0);

    // All requesting: strict rotation, with a 2-cycle gap between grants.
    do_reset();
    req = 16'hFFFF;
    for (int g = 0; g < 17; g++) begin
      wait_en(10, z);
      chk("r030.sel", int'(b_sel), g % 16);
      if (g > 0) chk("r030.gap", z, 2);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Hold limit of 4 revokes the grant and pulses timeout, then the same requester is re-granted.
    do_reset();
    req = 16'h0100;
    wait_en(10, z);
    chk("r031.sel", int'(b_sel), 8);
    n = 0;
    while (b_en && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("r031.len", n, 4);
    chk("r031.timeout", int'(b_to), 1);
    @(negedge clk);
    chk("r031.to_clear", int'(b_to), 0);
    chk("r031.idle_en", int'(b_en), 0);
    @(negedge clk);
    chk("r031.regrant", int'(b_en), 1);
    chk("r031.regrant_sel", int'(b_sel), 8);

    // Default hold limit of 255 on dut_a.
    req = '0;
    do_reset();
    req = 16'h0100;
    @(negedge clk);
    n = 0;
    while (a_en && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("hold255.len", n, 255);
    chk("hold255.timeout", int'(a_to), 1);
    req = '0;
    repeat (3) @(negedge clk);

    // done in the 4th cycle coincides with the hold limit: the release is normal.
    do_reset();
    req = 16'h0100;
    wait_en(10, z);
    repeat (3) @(negedge clk);
    chk("r034.en4", int'(b_en), 1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = '0;
    chk("r034.en416", int'(b_en), 0);
    chk("r034.timeout", int'(b_to), 0);
    repeat (3) @(negedge clk);

    // Pointer wrap: grant 14, then 15 wins over 0, then 0.
    do_reset();
    req = 16'h4000;
    wait_en(10, z);
    chk("r032.sel14", int'(b_sel), 14);
    done = 1'b1;
    req  = '0;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);
    req = 16'h8001;
    wait_en(10, z);
    chk("r032.sel15", int'(b_sel), 15);
    req = 16'h0001;
    @(negedge clk);
    chk("r032.drop_en", int'(b_en), 0);
    chk("r032.drop_to", int'(b_to), 0);
    wait_en(10, z);
    chk("r032.sel0", int'(b_sel), 0);
    // Other request bits changing do not disturb the owner.
    req = 16'h00F1;
    @(negedge clk);
    req = 16'h0003;
    @(negedge clk);
    chk("r023.en416", int'(b_en), 1);
    chk("r023.sel", int'(b_sel), 0);
    req = '0;
    @(negedge clk);
    chk("r023.rel", int'(b_en), 0);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-grant clears outputs before the next edge.
    req = 16'h0020;
    wait_en(10, z);
    chk("r033.sel5", int'(b_sel), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("r033.en416", int'(b_en), 0);
    chk("r033.sel", int'(b_sel), 0);
    chk("r033.busy", int'(b_busy), 0);
    chk("r033.a_en416", int'(a_en), 0);
    @(negedge clk);
    req   = 16'h0004;
    rst_n = 1'b1;
    wait_en(10, z);
    chk("r033.sel2", int'(b_sel), 2);
    req = '0;
    repeat (4) @(negedge clk);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
